// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, LSB-first data, optional even parity, stop bit; line idles high.
// Define SERIAL_TX_PARITY_EN to insert the even-parity bit between the last data bit and the stop bit.
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              serial_out,
  output logic              busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [IDX_W-1:0]  r_idx, w_idx;
  logic [DATA_W-1:0] r_shift, w_shift;
  logic              r_serial, w_serial;
  logic              r_busy, w_busy;
  logic              r_ready, w_ready;
  logic              w_bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic              r_par;
`endif

  assign w_bit_end = (r_cnt == CNT_LAST);

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_shift = r_shift;
    case (r_state)
      S_IDLE: begin
        if (tx_valid) begin
          w_state = S_START;
          w_shift = tx_data;
          w_cnt   = '0;
          w_idx   = '0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt   = '0;
          w_idx   = '0;
          w_state = S_DATA;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt   = '0;
          w_shift = r_shift >> 1;
          if (r_idx == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
            w_state = S_PARITY;
`else
            w_state = S_STOP;
`endif
          end else begin
            w_idx = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_cnt   = '0;
          w_state = S_STOP;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt   = '0;
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_serial = 1'b1;
    case (w_state)
      S_START:  w_serial = 1'b0;
      S_DATA:   w_serial = w_shift[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: w_serial = r_par;
`endif
      default:  w_serial = 1'b1;
    endcase
    w_busy  = (w_state != S_IDLE);
    w_ready = (w_state == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_serial <= 1'b1;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_idx    <= w_idx;
      r_shift  <= w_shift;
      r_serial <= w_serial;
      r_busy   <= w_busy;
      r_ready  <= w_ready;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Parity is taken from the word as accepted, not from later tx_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_par <= 1'b0;
    end else if (r_state == S_IDLE && tx_valid) begin
      r_par <= ^tx_data;
    end
  end
`endif

  assign tx_ready   = r_ready;
  assign serial_out = r_serial;
  assign busy       = r_busy;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx (DATA_W=8, CLKS_PER_BIT=4), parity-aware via SERIAL_TX_PARITY_EN.
module tb_serial_frame_tx;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F = (2 + DATA_W + P) * CPB;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              serial_out;
  logic              busy;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int acc_last = -1;
  int acc_prev = -1;

  serial_frame_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .serial_out (serial_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && tx_valid && tx_ready) begin
      acc_prev <= acc_last;
      acc_last <= cyc;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [DATA_W-1:0] w, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= DATA_W) return w[b-1];
    if (P == 1 && b == DATA_W + 1) return ^w;
    return 1'b1;
  endfunction

  // Called in an idle cycle; accepts w at the next edge and checks the whole frame.
  task automatic run_frame(input logic [DATA_W-1:0] w, input bit scramble, input bit hold);
    tx_data  = w;
    tx_valid = 1'b1;
    tick();
    if (!hold) tx_valid = 1'b0;
    for (int k = 0; k < F; k++) begin
      check($sformatf("line_%02h_c%0d", w, k), int'(serial_out), int'(exp_bit(w, k)));
      check($sformatf("busy_%02h_c%0d", w, k), int'(busy), 1);
      check($sformatf("rdy_%02h_c%0d", w, k), int'(tx_ready), 0);
      if (scramble) tx_data = DATA_W'($urandom);
      tick();
    end
    check($sformatf("end_rdy_%02h", w), int'(tx_ready), 1);
    check($sformatf("end_busy_%02h", w), int'(busy), 0);
    check($sformatf("end_line_%02h", w), int'(serial_out), 1);
  endtask

  initial begin
    reset    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_line_%0d", i), int'(serial_out), 1);
      check($sformatf("rst_rdy_%0d", i), int'(tx_ready), 1);
      check($sformatf("rst_busy_%0d", i), int'(busy), 0);
    end
    tx_valid = 1'b0;
    reset    = 1'b1;
    tick();
    check("post_rst_line", int'(serial_out), 1);
    check("post_rst_busy", int'(busy), 0);

    run_frame(8'hA5, 1'b0, 1'b0);
    run_frame(8'h07, 1'b0, 1'b0);

    run_frame(8'h00, 1'b0, 1'b1);
    run_frame(8'hFF, 1'b0, 1'b0);
    check("b2b_spacing", acc_last - acc_prev, F + 1);

    run_frame(8'h3C, 1'b1, 1'b0);

    tx_data  = 8'h55;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (4 * CPB + 1) tick();
    check("mid_bit3_line", int'(serial_out), 0);
    reset = 1'b0;
    #1;
    check("mid_rst_line", int'(serial_out), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_rdy", int'(tx_ready), 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("mid_rel_line", int'(serial_out), 1);
    run_frame(8'h81, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Single-line serial frame transmitter: accepts a parallel word over a valid/ready handshake and drives it out one bit at a time on a single data line (start bit, data LSB-first, optional parity, stop bit). It is the sending end of the single-bit `d` data path used by the team's latch/flop capture blocks. It sits between a parallel producer and a serial line feeding a capture/deserializer block. The line idles high.

## Interface
- `DATA_W`, 8: data word width, ≥1.
- `CLKS_PER_BIT`, 4: clock cycles each serial bit is held, ≥1.

- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `tx_data`  input  DATA_W  word to send; sampled only on accept.
- `tx_valid`  input  1  producer has a word.
- `tx_ready`  output  1  block can accept a word this cycle.
- `serial_out`  output  1  serial line; 1 = idle/mark.
- `busy`  output  1  frame in progress (START through STOP).

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - `tx_ready`=1, `busy`=0, `serial_out`=1.
  - Accept occurs when `tx_valid`&&`tx_ready` at a rising edge.
  - On accept: latch `tx_data` into the shift register and go to START.
- START: `serial_out`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - `serial_out` = shift register bit 0.
  - Every CLKS_PER_BIT cycles, shift right and increment the bit index.
  - After bit DATA_W−1 has been held for CLKS_PER_BIT cycles, go to PARITY if enabled, else to STOP.
- PARITY: `serial_out` = even parity (XOR of the latched word) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: `serial_out`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- `tx_ready`=0 and `busy`=1 in every state except IDLE. `tx_valid` is ignored outside IDLE.
- `tx_data` changes after accept do not affect the frame in flight.
- Counters:
  - Bit-time counter: width max(1,$clog2(CLKS_PER_BIT)). Counts 0..CLKS_PER_BIT−1 and wraps to 0 on each bit boundary.
  - Bit index: width max(1,$clog2(DATA_W)).
  - CLKS_PER_BIT=1 is legal: each bit lasts exactly one cycle.
- All outputs are registered; no combinational path from inputs to `serial_out`.

## Timing
- Reset (`reset`=0, asynchronous): state=IDLE, counters=0, shift register=0, `serial_out`=1, `tx_ready`=1, `busy`=0. Deassertion is sampled synchronously.
- Reset mid-frame: the line returns to 1 immediately (asynchronously). The frame is abandoned; no partial resume.
- Accept at edge N: `serial_out` falls and `busy` rises after edge N (valid for cycle N+1). `tx_ready` falls in the same cycle.
- Frame length F = (2 + DATA_W + P)·CLKS_PER_BIT cycles, where P=1 with parity, else 0.
- `tx_ready` returns to 1 in cycle N+1+F (IDLE). Minimum spacing between accepts is F+1 cycles, i.e. one idle cycle between frames.
- `tx_valid` held high continuously: words are taken back-to-back at that F+1 spacing.

## Configuration
- `SERIAL_TX_PARITY_EN` defined: the PARITY state exists, P=1, and an even-parity bit is inserted between the last data bit and the stop bit.
- Not defined: no PARITY state, P=0, and the stop bit immediately follows the last data bit.

## Test plan
All scenarios use DATA_W=8 and CLKS_PER_BIT=4.
- Reset:
  - Stimulus: hold `reset`=0 for 3 cycles with `tx_valid`=1.
  - Response: `serial_out`=1, `tx_ready`=1, `busy`=0 throughout; no frame starts until after release.
- Single frame, no parity:
  - Stimulus: accept 8'hA5.
  - Response: line sequence (4 cycles each) 0 | 1,0,1,0,0,1,0,1 | 1. `busy` high 40 cycles; `tx_ready` back at cycle 41 after accept.
- Parity:
  - Stimulus: with `SERIAL_TX_PARITY_EN`, send 8'hA5, then 8'h07.
  - Response: parity bit 0 for 8'hA5, 1 for 8'h07. Each frame 44 cycles.
- Back-to-back:
  - Stimulus: `tx_valid` held high with 8'h00 then 8'hFF.
  - Response: second accept exactly F+1=41 cycles after the first; one idle-high cycle between frames.
- Data stability:
  - Stimulus: change `tx_data` every cycle during a frame carrying 8'h3C.
  - Response: serialized bits still 0,0,1,1,1,1,0,0.
- Reset mid-frame:
  - Stimulus: assert `reset` during data bit 3.
  - Response: `serial_out`=1 immediately; after release, a new accept of 8'h81 sends a clean full frame.
